// File: rtl/i2d_core_defines.sv
// Shared i2d core types: data word, flags, opcodes and the decoded instruction bundle.
package i2d_core_defines;

  localparam int NREGS = 16;
  localparam int REG_W = $clog2(NREGS);

  typedef logic [31:0]      data_t;
  typedef logic [REG_W-1:0] reg_idx_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flag_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_LOAD = 4'h6
  } opcode_e;

  localparam opcode_e OPCODE_NOP = OP_NOP;

  typedef struct packed {
    opcode_e  opcode;
    logic     s;
    reg_idx_t rd;
    reg_idx_t ra;
    reg_idx_t rb;
    logic     imm_valid;
    data_t    imm;
    logic     is_load;
    logic     wr_en;
  } instr_t;

  function automatic instr_t nop_instr();
    instr_t i;
    i        = '0;
    i.opcode = OPCODE_NOP;
    return i;
  endfunction

endpackage

// File: rtl/core_operand_bypass.sv
// Resolves one source operand: r0, then EX forward (non-load), then WB forward, then register file.
module core_operand_bypass
  import i2d_core_defines::*;
(
  input  reg_idx_t addr_i,
  input  data_t    rf_data_i,
  input  logic     ex_valid_i,
  input  logic     ex_is_load_i,
  input  reg_idx_t ex_rd_i,
  input  data_t    ex_data_i,
  input  logic     wb_valid_i,
  input  reg_idx_t wb_rd_i,
  input  data_t    wb_data_i,
  output data_t    data_o
);

  logic ex_hit;
  logic wb_hit;

  // A forward with rd=0 can only hit addr 0, which is short-circuited first.
  assign ex_hit = ex_valid_i & ~ex_is_load_i & (ex_rd_i == addr_i);
  assign wb_hit = wb_valid_i & (wb_rd_i == addr_i);

  always_comb begin
    data_o = rf_data_i;
    if (addr_i == '0)  data_o = '0;
    else if (ex_hit)   data_o = ex_data_i;
    else if (wb_hit)   data_o = wb_data_i;
  end

endmodule

// File: rtl/core_operand_stage.sv
// Issue/operand stage: reads sources, applies EX/WB bypass, stalls on load-use, registers the EX bundle.
module core_operand_stage
  import i2d_core_defines::*;
#(
  parameter int NREGS = i2d_core_defines::NREGS,
  parameter int RW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          id_valid,
  output logic          id_ready,
  input  instr_t        id_instr,
  output logic [RW-1:0] rf_raddr_a,
  output logic [RW-1:0] rf_raddr_b,
  input  data_t         rf_rdata_a,
  input  data_t         rf_rdata_b,
  input  logic          fwd_ex_valid,
  input  logic [RW-1:0] fwd_ex_rd,
  input  data_t         fwd_ex_data,
  input  logic          fwd_ex_is_load,
  input  logic          fwd_wb_valid,
  input  logic [RW-1:0] fwd_wb_rd,
  input  data_t         fwd_wb_data,
  output logic          ex_valid,
  input  logic          ex_ready,
  output instr_t        ex_instr,
  output data_t         operand_a,
  output data_t         operand_b
);

  logic   ex_valid_q;
  instr_t ex_instr_q;
  data_t  operand_a_q, operand_b_q;

  logic   hazard, out_free, accept;
  data_t  operand_b_d;

  reg_idx_t src_addr [2];
  data_t    src_rf   [2];
  data_t    src_data [2];

  assign rf_raddr_a = id_instr.ra;
  assign rf_raddr_b = id_instr.rb;

  assign src_addr[0] = id_instr.ra;
  assign src_addr[1] = id_instr.rb;
  assign src_rf[0]   = rf_rdata_a;
  assign src_rf[1]   = rf_rdata_b;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      core_operand_bypass u_bypass (
        .addr_i       (src_addr[gi]),
        .rf_data_i    (src_rf[gi]),
        .ex_valid_i   (fwd_ex_valid),
        .ex_is_load_i (fwd_ex_is_load),
        .ex_rd_i      (fwd_ex_rd),
        .ex_data_i    (fwd_ex_data),
        .wb_valid_i   (fwd_wb_valid),
        .wb_rd_i      (fwd_wb_rd),
        .wb_data_i    (fwd_wb_data),
        .data_o       (src_data[gi])
      );
    end
  endgenerate

  // Load data is not available until WB, so a consumer of a load in EX waits one cycle.
  assign hazard = id_valid & fwd_ex_valid & fwd_ex_is_load & (fwd_ex_rd != '0) &
                  ((fwd_ex_rd == id_instr.ra) | (~id_instr.imm_valid & (fwd_ex_rd == id_instr.rb)));

  assign out_free    = ~ex_valid_q | ex_ready;
  assign id_ready    = ~rst & ~flush & ~hazard & out_free;
  assign accept      = id_valid & id_ready;
  assign operand_b_d = id_instr.imm_valid ? id_instr.imm : src_data[1];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ex_valid_q  <= 1'b0;
      ex_instr_q  <= nop_instr();
      operand_a_q <= '0;
      operand_b_q <= '0;
    end else if (out_free) begin
      // Hazard and idle both leave a bubble; bundle contents are kept but ignored.
      ex_valid_q <= accept;
      if (accept) begin
        ex_instr_q  <= id_instr;
        operand_a_q <= src_data[0];
        operand_b_q <= operand_b_d;
      end
    end
  end

  assign ex_valid  = ex_valid_q;
  assign ex_instr  = ex_instr_q;
  assign operand_a = operand_a_q;
  assign operand_b = operand_b_q;

endmodule

// File: tb/tb_core_operand_stage.sv
// Directed bench for core_operand_stage: bypass priority, load-use bubble, hold, flush and reset.
module tb_core_operand_stage;
  import i2d_core_defines::*;

  logic         clk = 1'b0;
  logic         rst, flush, id_valid, id_ready;
  instr_t       id_instr, ex_instr;
  logic [3:0]   rf_raddr_a, rf_raddr_b;
  data_t        rf_rdata_a, rf_rdata_b;
  logic         fwd_ex_valid, fwd_ex_is_load, fwd_wb_valid;
  logic [3:0]   fwd_ex_rd, fwd_wb_rd;
  data_t        fwd_ex_data, fwd_wb_data;
  logic         ex_valid, ex_ready;
  data_t        operand_a, operand_b;

  data_t regs [16];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rf_rdata_a = regs[rf_raddr_a];
  assign rf_rdata_b = regs[rf_raddr_b];

  core_operand_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .fwd_ex_valid(fwd_ex_valid), .fwd_ex_rd(fwd_ex_rd),
    .fwd_ex_data(fwd_ex_data), .fwd_ex_is_load(fwd_ex_is_load),
    .fwd_wb_valid(fwd_wb_valid), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_instr(ex_instr), .operand_a(operand_a), .operand_b(operand_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
    $display("check %-22s observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic instr_t mk(input opcode_e op, input int rd, input int ra, input int rb,
                                input logic immv, input data_t imm);
    instr_t i;
    i           = '0;
    i.opcode    = op;
    i.rd        = 4'(rd);
    i.ra        = 4'(ra);
    i.rb        = 4'(rb);
    i.imm_valid = immv;
    i.imm       = imm;
    i.wr_en     = 1'b1;
    return i;
  endfunction

  task automatic set_ex(input logic v, input int rd, input data_t d, input logic ld);
    fwd_ex_valid = v; fwd_ex_rd = 4'(rd); fwd_ex_data = d; fwd_ex_is_load = ld;
  endtask

  task automatic set_wb(input logic v, input int rd, input data_t d);
    fwd_wb_valid = v; fwd_wb_rd = 4'(rd); fwd_wb_data = d;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 32'h100 + i;
    regs[1] = 32'd5;
    regs[2] = 32'd7;
    rst = 1'b1; flush = 1'b0; ex_ready = 1'b1;
    id_valid = 1'b1; id_instr = mk(OP_ADD, 3, 1, 2, 1'b0, '0);
    set_ex(1'b0, 0, '0, 1'b0);
    set_wb(1'b0, 0, '0);

    // Reset state
    tick(); tick();
    chk("rst_id_ready", 32'(id_ready), 0);
    chk("rst_ex_valid", 32'(ex_valid), 0);
    chk("rst_opcode", 32'(ex_instr.opcode), 32'(OPCODE_NOP));
    chk("rst_operand_a", operand_a, 0);
    chk("rst_operand_b", operand_b, 0);
    rst = 1'b0;
    #1 chk("b2b_id_ready", 32'(id_ready), 1);

    // Back-to-back independent ADDs
    tick();
    chk("b2b0_valid", 32'(ex_valid), 1);
    chk("b2b0_a", operand_a, 5);
    chk("b2b0_b", operand_b, 7);
    chk("b2b0_rd", 32'(ex_instr.rd), 3);
    id_instr = mk(OP_ADD, 6, 2, 1, 1'b0, '0);
    tick();
    chk("b2b1_valid", 32'(ex_valid), 1);
    chk("b2b1_a", operand_a, 7);
    chk("b2b1_b", operand_b, 5);
    chk("b2b1_rd", 32'(ex_instr.rd), 6);
    id_valid = 1'b0;
    tick();
    chk("idle_valid", 32'(ex_valid), 0);

    // EX beats WB on the same register; WB used when EX misses
    set_ex(1'b1, 1, 32'h10, 1'b0);
    set_wb(1'b1, 1, 32'h20);
    id_valid = 1'b1; id_instr = mk(OP_ADD, 3, 1, 2, 1'b0, '0);
    tick();
    chk("prio_ex_a", operand_a, 32'h10);
    chk("prio_ex_b", operand_b, 7);
    set_ex(1'b1, 9, 32'h10, 1'b0);
    tick();
    chk("prio_wb_a", operand_a, 32'h20);

    // Load-use: one bubble, then forwarded from WB
    set_ex(1'b1, 4, 32'hDEAD, 1'b1);
    set_wb(1'b0, 0, '0);
    id_instr = mk(OP_ADD, 5, 4, 4, 1'b0, '0);
    #1 chk("lu_id_ready", 32'(id_ready), 0);
    tick();
    chk("lu_bubble", 32'(ex_valid), 0);
    set_ex(1'b0, 0, '0, 1'b0);
    set_wb(1'b1, 4, 32'h44);
    #1 chk("lu_id_ready2", 32'(id_ready), 1);
    tick();
    chk("lu_valid", 32'(ex_valid), 1);
    chk("lu_a", operand_a, 32'h44);
    chk("lu_b", operand_b, 32'h44);

    // Back-pressure: bundle held bit-stable, no re-resolution
    ex_ready = 1'b0;
    set_wb(1'b1, 4, 32'h55);
    id_instr = mk(OP_ADD, 7, 1, 2, 1'b0, '0);
    #1 chk("hold_id_ready", 32'(id_ready), 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("hold_valid", 32'(ex_valid), 1);
      chk("hold_a", operand_a, 32'h44);
      chk("hold_rd", 32'(ex_instr.rd), 5);
    end
    ex_ready = 1'b1;
    #1 chk("rel_id_ready", 32'(id_ready), 1);
    tick();
    chk("rel_valid", 32'(ex_valid), 1);
    chk("rel_rd", 32'(ex_instr.rd), 7);
    chk("rel_a", operand_a, 5);
    id_valid = 1'b0;
    tick();
    chk("rel_no_dup", 32'(ex_valid), 0);

    // r0 reads zero even when EX forwards rd=0; immediate replaces rb
    set_wb(1'b0, 0, '0);
    set_ex(1'b1, 0, 32'hFFFF_FFFF, 1'b0);
    id_valid = 1'b1; id_instr = mk(OP_ADD, 8, 0, 0, 1'b0, '0);
    tick();
    chk("r0_a", operand_a, 0);
    chk("r0_b", operand_b, 0);
    set_ex(1'b1, 0, 32'hFFFF_FFFF, 1'b1);
    id_instr = mk(OP_ADD, 9, 0, 2, 1'b1, 32'h8);
    #1 chk("r0_load_no_haz", 32'(id_ready), 1);
    tick();
    chk("imm_a", operand_a, 0);
    chk("imm_b", operand_b, 32'h8);
    set_ex(1'b1, 2, 32'hBEEF, 1'b1);
    id_instr = mk(OP_ADD, 11, 1, 2, 1'b1, 32'hC);
    #1 chk("imm_rb_no_haz", 32'(id_ready), 1);
    tick();
    chk("imm2_a", operand_a, 5);
    chk("imm2_b", operand_b, 32'hC);

    // Hazard while stalled: hold, no bubble
    ex_ready = 1'b0;
    set_ex(1'b1, 1, 32'hBEEF, 1'b1);
    id_instr = mk(OP_ADD, 10, 1, 2, 1'b0, '0);
    tick();
    chk("haz_hold_valid", 32'(ex_valid), 1);
    chk("haz_hold_rd", 32'(ex_instr.rd), 11);

    // Flush while holding
    flush = 1'b1;
    #1 chk("flush_id_ready", 32'(id_ready), 0);
    tick();
    chk("flush_valid", 32'(ex_valid), 0);
    chk("flush_a", operand_a, 0);
    flush = 1'b0;
    set_ex(1'b0, 0, '0, 1'b0);
    ex_ready = 1'b1;
    id_instr = mk(OP_ADD, 3, 1, 2, 1'b0, '0);
    tick();
    chk("post_flush_valid", 32'(ex_valid), 1);

    // Reset mid-stream drops the held instruction
    ex_ready = 1'b0;
    rst = 1'b1;
    #1 chk("rst_mid_id_ready", 32'(id_ready), 0);
    tick();
    chk("rst_mid_valid", 32'(ex_valid), 0);
    chk("rst_mid_a", operand_a, 0);
    chk("rst_mid_b", operand_b, 0);
    chk("rst_mid_opcode", 32'(ex_instr.opcode), 32'(OPCODE_NOP));
    rst = 1'b0;
    id_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
